// File: rtl/edge_conv_sequencer_if.sv
// Bus bundle between the edge-detect frame sequencer (master), its pixel RAM,
// the convolution peripheral and the result consumer.
interface edge_conv_sequencer_if #(
  parameter int ADDR_W = 17
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       cmd_out;
  logic [15:0]       pix_out;
  logic [15:0]       conv_in;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [ADDR_W-1:0] res_addr;

  modport master (
    input  start, mem_rdata, conv_in, res_ready,
    output busy, done, mem_rd, mem_addr, cmd_out, pix_out,
           res_valid, res_data, res_addr
  );

  modport slave (
    output start, mem_rdata, conv_in, res_ready,
    input  busy, done, mem_rd, mem_addr, cmd_out, pix_out,
           res_valid, res_data, res_addr
  );
endinterface

// File: rtl/edge_conv_sequencer.sv
// Walks every interior pixel of a frame, streams its 3x3 neighbourhood into the
// edge-detect peripheral and hands each result out on a valid/ready port.
module edge_conv_sequencer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  edge_conv_sequencer_if.master bus
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);

  localparam logic [X_W-1:0]    X_FIRST  = X_W'(1);
  localparam logic [X_W-1:0]    X_LAST   = X_W'(IMG_W - 2);
  localparam logic [X_W-1:0]    X_STEP   = X_W'(1);
  localparam logic [Y_W-1:0]    Y_FIRST  = Y_W'(1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(IMG_H - 2);
  localparam logic [Y_W-1:0]    Y_STEP   = Y_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_THREE  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_ROW    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_SKIP   = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] A_FIRST  = ADDR_W'(IMG_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAST,
    S_CONV,
    S_OUT
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_k;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_ctr_addr;
  logic [ADDR_W-1:0] r_win_addr;
  logic              r_done;
  logic              r_res_valid;
  logic [15:0]       r_res_data;
  logic [ADDR_W-1:0] r_res_addr;

  logic              w_last_pix;
  logic              w_row_end;
  logic              w_mem_rd;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [15:0]       w_cmd;
  logic [15:0]       w_pix;

  assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_row_end  = (r_x == X_LAST);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    w_mem_addr   = '0;
    w_cmd        = '0;
    w_pix        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_RD;
      end
      S_RD: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = r_win_addr;
        // Pixel k-1 arrives one cycle after its read, overlapping the next read.
        if (r_k != 4'd0) begin
          w_cmd = 16'h0001 << (r_k - 4'd1);
          w_pix = bus.mem_rdata;
        end
        if (r_k == 4'd8) w_next_state = S_LAST;
      end
      S_LAST: begin
        w_cmd        = 16'h0100;
        w_pix        = bus.mem_rdata;
        w_next_state = S_CONV;
      end
      S_CONV: begin
        w_cmd        = 16'h0200;
        w_next_state = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) w_next_state = w_last_pix ? S_IDLE : S_RD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_ctr_addr  <= '0;
      r_win_addr  <= '0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k        <= '0;
            r_x        <= X_FIRST;
            r_y        <= Y_FIRST;
            r_ctr_addr <= A_FIRST;
            r_win_addr <= '0;
          end
        end
        S_RD: begin
          r_k <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
          // End of a window row jumps to the left column of the next row.
          r_win_addr <= r_win_addr + (((r_k == 4'd2) || (r_k == 4'd5)) ? A_SKIP : A_ONE);
        end
        S_CONV: begin
          r_res_data  <= bus.conv_in;
          r_res_addr  <= r_ctr_addr;
          r_res_valid <= 1'b1;
        end
        S_OUT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (w_last_pix) begin
              r_done <= 1'b1;
            end else if (w_row_end) begin
              // Skip the right border of this row and the left border of the next.
              r_x        <= X_FIRST;
              r_y        <= r_y + Y_STEP;
              r_ctr_addr <= r_ctr_addr + A_THREE;
              r_win_addr <= r_ctr_addr - A_SKIP;
            end else begin
              r_x        <= r_x + X_STEP;
              r_ctr_addr <= r_ctr_addr + A_ONE;
              r_win_addr <= r_ctr_addr - A_ROW;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.cmd_out   = w_cmd;
  assign bus.pix_out   = w_pix;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_addr  = r_res_addr;

endmodule

// File: tb/tb_edge_conv_sequencer.sv
// Directed bench: a 4x4 and a 3x3 sequencer, each with a RAM model and a
// behavioural edge-detect peripheral, checked against hand-computed values.
module tb_edge_conv_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  edge_conv_sequencer_if #(.ADDR_W(5)) if4 ();
  edge_conv_sequencer_if #(.ADDR_W(4)) if3 ();

  edge_conv_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(5)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  edge_conv_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(4)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  logic [15:0] ram4 [16];
  logic [15:0] ram3 [9];
  logic [15:0] per4 [9];
  logic [15:0] per3 [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if4.mem_rd) if4.mem_rdata <= ram4[if4.mem_addr[3:0]];
    if (if3.mem_rd) if3.mem_rdata <= ram3[if3.mem_addr];
    for (int k = 0; k < 9; k++) begin
      if (if4.cmd_out == (16'h0001 << k)) per4[k] <= if4.pix_out;
      if (if3.cmd_out == (16'h0001 << k)) per3[k] <= if3.pix_out;
    end
  end

  function automatic logic [15:0] laplace(input logic [15:0] p [9]);
    logic [15:0] s;
    s = p[4] << 3;
    for (int i = 0; i < 9; i++) if (i != 4) s = s - p[i];
    return s;
  endfunction

  always_comb begin
    if4.conv_in = if4.cmd_out[9] ? laplace(per4) : 16'h0000;
    if3.conv_in = if3.cmd_out[9] ? laplace(per3) : 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero4(input string pfx);
    check({pfx, " busy"},      32'(if4.busy),      0);
    check({pfx, " done"},      32'(if4.done),      0);
    check({pfx, " mem_rd"},    32'(if4.mem_rd),    0);
    check({pfx, " mem_addr"},  32'(if4.mem_addr),  0);
    check({pfx, " cmd_out"},   32'(if4.cmd_out),   0);
    check({pfx, " pix_out"},   32'(if4.pix_out),   0);
    check({pfx, " res_valid"}, 32'(if4.res_valid), 0);
    check({pfx, " res_data"},  32'(if4.res_data),  0);
    check({pfx, " res_addr"},  32'(if4.res_addr),  0);
  endtask

  // One 3x3 frame: checks every cycle of the single window, then done.
  task automatic run3(input string pfx, input logic [15:0] v [9], input logic [15:0] exp_res);
    for (int i = 0; i < 9; i++) ram3[i] = v[i];
    if3.res_ready = 1'b1;
    @(posedge clk); #1;
    if3.start = 1'b1;
    @(posedge clk); #1;
    if3.start = 1'b0;
    check({pfx, " busy"},     32'(if3.busy),     1);
    check({pfx, " rd0 mem_rd"}, 32'(if3.mem_rd), 1);
    check({pfx, " rd0 addr"}, 32'(if3.mem_addr), 0);
    check({pfx, " rd0 cmd"},  32'(if3.cmd_out),  0);
    for (int k = 1; k < 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s rd%0d addr", pfx, k), 32'(if3.mem_addr), k);
      check($sformatf("%s rd%0d cmd", pfx, k),  32'(if3.cmd_out),  32'h1 << (k - 1));
      check($sformatf("%s rd%0d pix", pfx, k),  32'(if3.pix_out),  32'(v[k-1]));
    end
    @(posedge clk); #1;
    check({pfx, " last cmd"},    32'(if3.cmd_out), 32'h0100);
    check({pfx, " last pix"},    32'(if3.pix_out), 32'(v[8]));
    check({pfx, " last mem_rd"}, 32'(if3.mem_rd),  0);
    @(posedge clk); #1;
    check({pfx, " conv cmd"}, 32'(if3.cmd_out), 32'h0200);
    @(posedge clk); #1;
    check({pfx, " out cmd"},   32'(if3.cmd_out),   0);
    check({pfx, " res_valid"}, 32'(if3.res_valid), 1);
    check({pfx, " res_data"},  32'(if3.res_data),  32'(exp_res));
    check({pfx, " res_addr"},  32'(if3.res_addr),  4);
    @(posedge clk); #1;
    check({pfx, " done"},      32'(if3.done),      1);
    check({pfx, " idle busy"}, 32'(if3.busy),      0);
    check({pfx, " res_valid low"}, 32'(if3.res_valid), 0);
    @(posedge clk); #1;
    check({pfx, " done pulse"}, 32'(if3.done), 0);
  endtask

  // One 4x4 frame with an optional result stall on the first pixel and an
  // optional start pulse while busy. n counts cycles from raising start.
  task automatic run4(input string pfx, input int stall, input bit mid_start,
                      input logic [15:0] exp_data, input int exp_done_n);
    logic [4:0] exp_addr [4];
    int n, hs, stall_left, first_hs, second_hs;
    exp_addr = '{5'd5, 5'd6, 5'd9, 5'd10};
    n = 0; hs = 0; stall_left = stall; first_hs = 0; second_hs = 0;
    if4.res_ready = (stall == 0);
    @(posedge clk); #1;
    if4.start = 1'b1;
    while (n < 400 && if4.done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if4.start = mid_start && (n == 20);
      if (n == 1) check({pfx, " busy"}, 32'(if4.busy), 1);
      if (if4.res_valid === 1'b1) begin
        if (stall_left > 0) begin
          check($sformatf("%s stall%0d data", pfx, stall_left), 32'(if4.res_data), 32'(exp_data));
          check($sformatf("%s stall%0d addr", pfx, stall_left), 32'(if4.res_addr), 32'(exp_addr[0]));
          stall_left--;
        end else begin
          if4.res_ready = 1'b1;
          if (hs < 4) begin
            check($sformatf("%s res%0d data", pfx, hs), 32'(if4.res_data), 32'(exp_data));
            check($sformatf("%s res%0d addr", pfx, hs), 32'(if4.res_addr), 32'(exp_addr[hs]));
          end
          if (hs == 0) first_hs = n;
          if (hs == 1) second_hs = n;
          hs++;
        end
      end
    end
    check({pfx, " done seen"},     32'(if4.done), 1);
    check({pfx, " done cycle"},    32'(n), 32'(exp_done_n));
    check({pfx, " handshakes"},    32'(hs), 4);
    check({pfx, " first pixel"},   32'(first_hs), 32'(12 + stall));
    check({pfx, " second pixel"},  32'(second_hs - first_hs), 12);
    @(posedge clk); #1;
    check({pfx, " done pulse"}, 32'(if4.done), 0);
    check({pfx, " idle busy"},  32'(if4.busy), 0);
  endtask

  logic [15:0] va [9];
  logic [15:0] vb [9];
  logic [15:0] vc [9];

  initial begin
    int  n;
    bit  seen_done;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    if4.start = 1'b0; if4.res_ready = 1'b1;
    if3.start = 1'b0; if3.res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      per4[i] = '0;
      per3[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero4("reset");
    check("reset dut3 busy", 32'(if3.busy),    0);
    check("reset dut3 cmd",  32'(if3.cmd_out), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_zero4("post-reset");

    va = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
    run3("centre5", va, 16'h0028);
    vb = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd100, 16'd6, 16'd7, 16'd8, 16'd9};
    run3("ramp", vb, 16'h02F8);
    vc = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
    run3("wrap", vc, 16'hFFF8);

    for (int i = 0; i < 16; i++) ram4[i] = 16'd10;
    run4("const", 0, 1'b0, 16'h0000, 49);

    // Laplacian of i*i on a 4-wide frame is -102 at every interior pixel.
    for (int i = 0; i < 16; i++) ram4[i] = 16'(i * i);
    run4("stall", 5, 1'b1, 16'hFF9A, 54);

    if4.res_ready = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b1;
    for (n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if4.start = 1'b0;
    end
    check("mid rd mem_rd",   32'(if4.mem_rd),   1);
    check("mid rd res_addr", 32'(if4.res_addr), 5);
    check("mid rd res_data", 32'(if4.res_data), 32'hFF9A);
    #2 reset = 1'b1;
    #1;
    check_zero4("async reset");
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if4.done === 1'b1 || if4.busy === 1'b1) seen_done = 1'b1;
    end
    check("no done after reset", 32'(seen_done), 0);

    run4("restart", 0, 1'b0, 16'hFF9A, 49);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edge_conv_sequencer.md
# edge_conv_sequencer

Bus master that drives the 3x3 edge-detect convolution peripheral across a whole frame. For every interior pixel of an IMG_W x IMG_H 16-bit frame held in a synchronous-read pixel RAM, it fetches the 3x3 neighbourhood and strobes each pixel into the peripheral with the one-hot command word. It then raises the convolution-read command, captures the result, and presents it with its frame address on a valid/ready result port.

## Interface
- IMG_W, 320, frame width in pixels (>= 3)
- IMG_H, 240, frame height in pixels (>= 3)
- ADDR_W, 17, pixel address width; 2^ADDR_W >= IMG_W*IMG_H
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- start  in  1  single-cycle frame start request; ignored unless idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result is accepted
- mem_rd  out  1  pixel RAM read enable
- mem_addr  out  ADDR_W  pixel RAM read address (row-major, y*IMG_W+x)
- mem_rdata  in  16  pixel RAM data, valid exactly 1 cycle after mem_rd
- cmd_out  out  16  command word to peripheral (one-hot or zero)
- pix_out  out  16  pixel data to peripheral
- conv_in  in  16  peripheral result bus, valid while cmd_out[9]=1
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  16  captured convolution result (two's complement)
- res_addr  out  ADDR_W  address of centre pixel the result belongs to

## Operation
- Output pixels: x = 1..IMG_W-2 inner loop, y = 1..IMG_H-2 outer loop; border pixels get no result.
- Window index k = 0..8: dy = k/3 - 1, dx = k%3 - 1; k=4 is the centre. The pixel at (x+dx, y+dy) goes to peripheral command 1<<k (0x0001..0x0100).
- Addresses come from incremental counters (row base += IMG_W); no multiplier.
- FSM states:
  - IDLE: cmd_out=0, mem_rd=0. On start, clear x=1, y=1 and go to RD.
  - RD: for 9 cycles (k=0..8), mem_rd=1 and mem_addr = window address k. In cycles 2..9, cmd_out = 1<<(k-1) and pix_out = mem_rdata. Then go to LAST.
  - LAST: cmd_out=0x0100, pix_out=mem_rdata (pixel 9), mem_rd=0. Go to CONV.
  - CONV: cmd_out=0x0200. Capture conv_in into res_data at the closing edge, set res_addr = y*IMG_W+x and res_valid=1. Go to OUT.
  - OUT: cmd_out=0. Hold res_valid/res_data/res_addr stable until res_ready=1. On the handshake edge, if this was the last pixel go to IDLE and pulse done; else advance x (wrap to 1 and increment y at IMG_W-2) and go to RD.
- Consecutive strobes change cmd_out directly from one one-hot value to the next, so every pixel produces a distinct command value.
- The result is not recomputed. res_data is the raw 16-bit wrap-around value: 8*centre minus the sum of the 8 neighbours, mod 2^16.
- start while busy: ignored; the frame in progress continues unaffected.

## Timing
- Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, cmd_out=0, pix_out=0, res_valid=0, res_data=0, res_addr=0. FSM is in IDLE.
- Reset mid-frame: asynchronous return to all reset values. The partial frame is abandoned and no done is issued. A new start is needed afterwards.
- Per-pixel cost: 9 (RD) + 1 (LAST) + 1 (CONV) + 1 (OUT, with res_ready high) = 12 cycles minimum. Each extra cycle of res_ready low adds one cycle.
- Frame latency with res_ready held high: 12*(IMG_W-2)*(IMG_H-2) cycles from start to the last handshake. done follows in the next cycle.
- mem_rdata is sampled exactly one cycle after its mem_rd. No other RAM latency is supported.
- cmd_out is never 0x0200 outside CONV. cmd_out is zero in IDLE and OUT.

## Test plan
- IMG_W=4, IMG_H=4, constant frame 10 -> 4 results, all res_data=0x0000, with res_addr order 5, 6, 9, 10. done 49 cycles after start.
- IMG_W=3, IMG_H=3, centre=5, others=0 -> a single result 0x0028 at res_addr 4. The cmd_out sequence is 0x0001..0x0100, then 0x0200, with the matching pix_out values.
- Centre=0, neighbours=1 -> res_data=0xFFF8 (-8, wrap-around check).
- res_ready held low for 5 cycles in OUT -> res_valid, res_data and res_addr stay stable throughout. Exactly one handshake occurs, and per-pixel time is 17 cycles.
- start pulsed mid-frame -> ignored, with result count and order unchanged. Reset asserted during RD -> all outputs are zero immediately. No done is issued, and a later start restarts from res_addr IMG_W+1.
